// File: rtl/ncl_pkg.sv
// ncl_pkg: shared dual-rail (NCL) constants, encode/decode helpers and the sequencer state type
package ncl_pkg;

    // Helpers work on up to DR_MAX logical bits; callers size-cast in and out.
    localparam int DR_MAX = 64;

    localparam logic [1:0] DR_NULL  = 2'b00;
    localparam logic [1:0] DR_FALSE = 2'b01;
    localparam logic [1:0] DR_TRUE  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        OUT_DATA,
        OUT_NULL,
        ERR
    } state_t;

    // Encode the low w bits of v as dual-rail pairs; pairs above w stay NULL.
    function automatic logic [2*DR_MAX-1:0] dr_encode(input logic [DR_MAX-1:0] v, input int w);
        logic [2*DR_MAX-1:0] e;
        e = '0;
        for (int i = 0; i < DR_MAX; i++) begin
            if (i < w) e[2*i +: 2] = v[i] ? DR_TRUE : DR_FALSE;
        end
        return e;
    endfunction

    // Decode the low w dual-rail pairs of d by their rail-1; only meaningful on a complete word.
    function automatic logic [DR_MAX-1:0] dr_decode(input logic [2*DR_MAX-1:0] d, input int w);
        logic [DR_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < DR_MAX; i++) begin
            if (i < w) v[i] = d[2*i+1];
        end
        return v;
    endfunction

endpackage

// File: rtl/dr_complete_detect.sv
// dr_complete_detect: classifies a dual-rail bus as complete, all-NULL or containing an illegal 11 pair
module dr_complete_detect #(
    parameter int WIDTH = 1
) (
    input  logic [2*WIDTH-1:0] d_i,
    output logic               complete_o,
    output logic               allnull_o,
    output logic               illegal_o
);

    // Every pair one-hot means complete; any pair with both rails set is illegal.
    always_comb begin
        complete_o = 1'b1;
        illegal_o  = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            complete_o = complete_o & (d_i[2*i] ^ d_i[2*i+1]);
            illegal_o  = illegal_o | (d_i[2*i] & d_i[2*i+1]);
        end
    end

    assign allnull_o = ~|d_i;

endmodule

// File: rtl/compl2_dr_seq.sv
// compl2_dr_seq: digit-serial dual-rail conditional two's-complement negator with four-phase handshake
module compl2_dr_seq
    import ncl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] a,
    input  logic [1:0]         sub,
    output logic               ack,
    output logic [2*WIDTH-1:0] r,
    output logic [1:0]         ovf,
    input  logic               r_ack,
    output logic               err
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    dig_q, dig_d;
    logic             s_q, s_d;
    logic             carry_q, carry_d;
    logic             null_seen_q, null_seen_d;
    logic             ack_q, ack_d;
    logic             neg_ovf_q, neg_ovf_d;

    logic             complete, allnull, illegal;
    logic [WIDTH-1:0] a_dec;
    logic [DIGIT:0]   sum;

    dr_complete_detect #(
        .WIDTH(WIDTH + 1)
    ) u_det (
        .d_i       ({a, sub}),
        .complete_o(complete),
        .allnull_o (allnull),
        .illegal_o (illegal)
    );

    assign a_dec = WIDTH'(dr_decode((2*DR_MAX)'(a), WIDTH));

    // One digit of (A xor S) + carry; op_q is shifted so its low digit is always the current one.
    assign sum = {1'b0, op_q[DIGIT-1:0] ^ {DIGIT{s_q}}} + {{DIGIT{1'b0}}, carry_q};

    // Next-state logic: capture, digit-serial add, output handshake, error recovery, null tracking.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        res_d       = res_q;
        dig_d       = dig_q;
        s_d         = s_q;
        carry_d     = carry_q;
        null_seen_d = null_seen_q;
        ack_d       = ack_q;
        neg_ovf_d   = neg_ovf_q;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (illegal) begin
                    state_d = ERR;
                end else if (complete) begin
                    state_d     = CALC;
                    op_d        = a_dec;
                    res_d       = '0;
                    dig_d       = '0;
                    s_d         = sub[1];
                    carry_d     = sub[1];
                    null_seen_d = 1'b0;
                    ack_d       = 1'b1;
                    neg_ovf_d   = sub[1] && (a_dec == MIN_NEG);
                end
            end
            CALC: begin
                op_d    = op_q >> DIGIT;
                res_d   = (res_q >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
                carry_d = sum[DIGIT];
                dig_d   = dig_q + 1'b1;
                state_d = (dig_q == CW'(K - 1)) ? OUT_DATA : CALC;
            end
            OUT_DATA: state_d = r_ack ? OUT_NULL : OUT_DATA;
            OUT_NULL: state_d = (!r_ack && null_seen_q) ? IDLE : OUT_NULL;
            ERR:      state_d = allnull ? IDLE : ERR;
            default:  state_d = IDLE;
        endcase
        if ((state_q inside {CALC, OUT_DATA, OUT_NULL}) && allnull) begin
            null_seen_d = 1'b1;
            ack_d       = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            res_q       <= '0;
            dig_q       <= '0;
            s_q         <= 1'b0;
            carry_q     <= 1'b0;
            null_seen_q <= 1'b0;
            ack_q       <= 1'b0;
            neg_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            res_q       <= res_d;
            dig_q       <= dig_d;
            s_q         <= s_d;
            carry_q     <= carry_d;
            null_seen_q <= null_seen_d;
            ack_q       <= ack_d;
            neg_ovf_q   <= neg_ovf_d;
        end
    end

    // Outputs are pure functions of the registered state, so r is never partially DATA.
    assign ack = ack_q;
    assign err = (state_q == ERR);
    assign r   = (state_q == OUT_DATA) ? (2*WIDTH)'(dr_encode(DR_MAX'(res_q), WIDTH)) : '0;
    assign ovf = (state_q == OUT_DATA) ? (neg_ovf_q ? DR_TRUE : DR_FALSE) : DR_NULL;

endmodule

// File: tb/tb_compl2_dr_seq.sv
// tb_compl2_dr_seq: scoreboard bench for compl2_dr_seq with directed handshake cases and random words
module tb_compl2_dr_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [1:0]  sub;
    logic        ack;
    logic [15:0] r;
    logic [1:0]  ovf;
    logic        r_ack;
    logic        err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] exp_q[$];
    logic        prev_data = 1'b0;
    logic [15:0] prev_r = '0;

    compl2_dr_seq #(.WIDTH(8), .DIGIT(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .sub  (sub),
        .ack  (ack),
        .r    (r),
        .ovf  (ovf),
        .r_ack(r_ack),
        .err  (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] enc(input logic [7:0] v);
        logic [15:0] e;
        for (int i = 0; i < 8; i++) e[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return e;
    endfunction

    // Reference: negation as (256 - A) mod 256; overflow only for negating -128.
    function automatic logic [17:0] model(input int v, input bit s);
        int res;
        res = s ? (256 - v) % 256 : v;
        return {enc(8'(res)), (s && v == 128) ? 2'b10 : 2'b01};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, req);
        end
    endtask

    // which: 0 = r is DATA, 1 = ack
    task automatic wait_sig(input int which, input bit val, input string nm);
        int n = 0;
        while ((((which == 0) ? (r != 0) : ack) != val) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout, got %0b required %0b", nm, !val, val);
        end
    endtask

    task automatic present(input int v, input bit s);
        a   = enc(8'(v));
        sub = s ? 2'b10 : 2'b01;
        exp_q.push_back(model(v, s));
    endtask

    task automatic go_null();
        a   = '0;
        sub = 2'b00;
    endtask

    task automatic do_word(input int v, input bit s, input int nd, input int rd);
        present(v, s);
        wait_sig(1, 1'b1, "ack rise");
        repeat (nd) tick();
        go_null();
        wait_sig(0, 1'b1, "r data");
        repeat (rd) tick();
        r_ack = 1'b1;
        wait_sig(0, 1'b0, "r null");
        r_ack = 1'b0;
        tick();
    endtask

    // Monitor: each new DATA presentation on r is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst) begin
            prev_data = 1'b0;
        end else begin
            if (r != 0 && !prev_data) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected output: got %h/%b required none", r, ovf);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    if ({r, ovf} !== e) begin
                        n_fail++;
                        $display("FAIL result: got r=%h ovf=%b required r=%h ovf=%b", r, ovf, e[17:2], e[1:0]);
                    end
                end
            end else if (r != 0 && prev_data) begin
                n_tests++;
                if (r !== prev_r) begin
                    n_fail++;
                    $display("FAIL r stability: got %h required %h", r, prev_r);
                end
            end
            prev_data = (r != 0);
            prev_r    = r;
        end
    end

    initial begin
        int cnt;
        int v;
        bit s;
        rst   = 1'b1;
        a     = '0;
        sub   = 2'b00;
        r_ack = 1'b0;
        repeat (3) tick();
        chk("reset r", 32'(r), 32'h0);
        chk("reset ovf", 32'(ovf), 32'h0);
        chk("reset ack", 32'(ack), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        rst = 1'b0;
        tick();

        // Pass-through with latency measurement from the capture cycle.
        present(5, 1'b0);
        tick();
        chk("ack after capture", 32'(ack), 32'h1);
        cnt = 1;
        while (r == 0 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("latency", 32'(cnt), 32'd5);
        go_null();
        tick();
        r_ack = 1'b1;
        wait_sig(0, 1'b0, "r null");
        r_ack = 1'b0;
        tick();

        do_word(5, 1'b1, 0, 0);
        do_word(0, 1'b1, 1, 1);
        do_word(128, 1'b1, 0, 2);
        do_word(128, 1'b0, 2, 0);
        do_word(127, 1'b1, 0, 0);

        // Illegal pair.
        a   = 16'h5567;
        sub = 2'b01;
        tick();
        chk("err set", 32'(err), 32'h1);
        chk("err r", 32'(r), 32'h0);
        chk("err ack", 32'(ack), 32'h0);
        go_null();
        tick();
        chk("err clear", 32'(err), 32'h0);
        do_word(200, 1'b1, 0, 0);

        // Reset during the second CALC cycle.
        present(51, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midreset r", 32'(r), 32'h0);
        chk("midreset ack", 32'(ack), 32'h0);
        chk("midreset err", 32'(err), 32'h0);
        exp_q.delete();
        go_null();
        rst = 1'b0;
        tick();
        do_word(51, 1'b1, 0, 0);

        // r held while r_ack low, then NULL while r_ack stays high.
        present(99, 1'b1);
        wait_sig(1, 1'b1, "ack rise");
        go_null();
        wait_sig(0, 1'b1, "r data");
        repeat (10) begin
            tick();
            chk("r held", 32'(r), 32'(enc(8'(157))));
        end
        r_ack = 1'b1;
        repeat (10) begin
            tick();
            chk("r null held", 32'(r), 32'h0);
        end
        r_ack = 1'b0;
        tick();

        // Input NULL mid-CALC drops ack before the result appears.
        present(17, 1'b0);
        tick();
        go_null();
        tick();
        chk("ack mid calc", 32'(ack), 32'h0);
        chk("r mid calc", 32'(r), 32'h0);
        wait_sig(0, 1'b1, "r data");
        r_ack = 1'b1;
        wait_sig(0, 1'b0, "r null");
        r_ack = 1'b0;
        tick();

        // Input NULL arrives after r_ack falls: stay in OUT_NULL until it does.
        present(66, 1'b1);
        wait_sig(1, 1'b1, "ack rise");
        wait_sig(0, 1'b1, "r data");
        r_ack = 1'b1;
        wait_sig(0, 1'b0, "r null");
        r_ack = 1'b0;
        repeat (4) tick();
        chk("ack while waiting null", 32'(ack), 32'h1);
        go_null();
        tick();
        tick();
        chk("ack after late null", 32'(ack), 32'h0);

        // New DATA presented while still in OUT_NULL with r_ack high.
        present(33, 1'b0);
        wait_sig(1, 1'b1, "ack rise");
        go_null();
        wait_sig(0, 1'b1, "r data");
        r_ack = 1'b1;
        wait_sig(0, 1'b0, "r null");
        present(34, 1'b1);
        repeat (3) tick();
        chk("no early capture", 32'(ack), 32'h0);
        r_ack = 1'b0;
        tick();
        tick();
        chk("capture after idle", 32'(ack), 32'h1);
        go_null();
        wait_sig(0, 1'b1, "r data");
        r_ack = 1'b1;
        wait_sig(0, 1'b0, "r null");
        r_ack = 1'b0;
        tick();

        // Random words.
        for (int i = 0; i < 30; i++) begin
            v = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) v = 128;
            if ($urandom_range(0, 7) == 0) v = 0;
            s = 1'($urandom_range(0, 1));
            do_word(v, s, $urandom_range(0, 6), $urandom_range(0, 3));
        end

        repeat (3) tick();
        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
